// File: rtl/digit_entry_pkg.sv
// Shared types and ASCII constants for the decimal digit entry controller.
package digit_entry_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    OUT   = 2'd2,
    HALT  = 2'd3
  } entry_state_t;

  localparam logic [7:0] CH_ZERO = 8'h30;
  localparam logic [7:0] CH_NINE = 8'h39;
  localparam logic [7:0] CH_NL   = 8'h0A;
  localparam logic [7:0] CH_CR   = 8'h0D;

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= CH_ZERO) && (c <= CH_NINE);
  endfunction

  // Used at elaboration to validate the result width against MAX_DIGITS.
  function automatic longint unsigned pow10(input int unsigned n);
    longint unsigned p;
    p = 1;
    for (int unsigned i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

endpackage

// File: rtl/digit_entry_ctrl_dec_accum.sv
// Combinational decimal shift-in: nxt = acc*10 + d using shift-and-add.
module dec_accum #(
  parameter int VAL_W = 14
) (
  input  logic [VAL_W-1:0] acc,
  input  logic [3:0]       d,
  output logic [VAL_W-1:0] nxt
);

  always_comb begin
    nxt = (acc << 3) + (acc << 1) + VAL_W'(d);
  end

endmodule

// File: rtl/digit_entry_ctrl.sv
// Decimal entry sequencer: accumulates ASCII digits, emits the number on
// newline through a valid/ready port, and halts on any other non-digit.
module digit_entry_ctrl
  import digit_entry_pkg::*;
#(
  parameter int MAX_DIGITS = 4,
  parameter int VAL_W      = 14,
  parameter int CNT_W      = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       char_in,
  input  logic             char_valid,
  output logic             char_ready,
  output logic [VAL_W-1:0] val_out,
  output logic             val_ovf,
  output logic             val_valid,
  input  logic             val_ready,
  output logic [CNT_W-1:0] digit_cnt,
  output logic             halted
);

  if ((64'd1 << VAL_W) < pow10(MAX_DIGITS)) begin : g_bad_val_w
    $error("VAL_W too narrow for MAX_DIGITS decimal digits");
  end
  if ((64'd1 << CNT_W) <= 64'(MAX_DIGITS)) begin : g_bad_cnt_w
    $error("CNT_W too narrow to count MAX_DIGITS");
  end

  entry_state_t     state;
  logic [VAL_W-1:0] acc;
  logic [VAL_W-1:0] acc_nxt;
  logic             ovf_flag;
  logic [3:0]       dval;

  assign dval       = char_in[3:0];
  assign char_ready = (state == IDLE) || (state == ACCUM);

  dec_accum #(.VAL_W(VAL_W)) u_dec_accum (
    .acc (acc),
    .d   (dval),
    .nxt (acc_nxt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      ovf_flag  <= 1'b0;
      digit_cnt <= '0;
      val_out   <= '0;
      val_ovf   <= 1'b0;
      val_valid <= 1'b0;
      halted    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (char_valid) begin
            if (is_digit(char_in)) begin
              acc       <= VAL_W'(dval);
              digit_cnt <= CNT_W'(1);
              state     <= ACCUM;
            end else if (char_in != CH_NL && char_in != CH_CR) begin
              halted <= 1'b1;
              state  <= HALT;
            end
          end
        end
        ACCUM: begin
          if (char_valid) begin
            if (is_digit(char_in)) begin
              // Digits past MAX_DIGITS are dropped; only the flag records them.
              if (digit_cnt < CNT_W'(MAX_DIGITS)) begin
                acc       <= acc_nxt;
                digit_cnt <= digit_cnt + CNT_W'(1);
              end else begin
                ovf_flag <= 1'b1;
              end
            end else if (char_in == CH_NL) begin
              val_out   <= acc;
              val_ovf   <= ovf_flag;
              val_valid <= 1'b1;
              state     <= OUT;
            end else if (char_in != CH_CR) begin
              acc       <= '0;
              digit_cnt <= '0;
              ovf_flag  <= 1'b0;
              halted    <= 1'b1;
              state     <= HALT;
            end
          end
        end
        OUT: begin
          if (val_ready) begin
            val_valid <= 1'b0;
            acc       <= '0;
            digit_cnt <= '0;
            ovf_flag  <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= HALT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_digit_entry_ctrl.sv
// Self-checking bench: directed scenarios plus random byte streams, compared
// every cycle against a queue-based model of the entry protocol.
module tb_digit_entry_ctrl;

  localparam int MAXD  = 4;
  localparam int VAL_W = 14;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [7:0]       char_in;
  logic             char_valid;
  logic             char_ready;
  logic [VAL_W-1:0] val_out;
  logic             val_ovf;
  logic             val_valid;
  logic             val_ready;
  logic [CNT_W-1:0] digit_cnt;
  logic             halted;

  digit_entry_ctrl #(.MAX_DIGITS(MAXD), .VAL_W(VAL_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .char_in    (char_in),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .val_out    (val_out),
    .val_ovf    (val_ovf),
    .val_valid  (val_valid),
    .val_ready  (val_ready),
    .digit_cnt  (digit_cnt),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // Model: digits of the line in progress, one pending output slot, halt flag.
  int m_digits[$];
  int m_cnt      = 0;
  bit m_pend     = 0;
  bit m_halted   = 0;
  int m_last_val = 0;
  bit m_last_ovf = 0;
  int n_emitted  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_ready();
    return !m_halted && !m_pend;
  endfunction

  function automatic void model_reset();
    m_digits.delete();
    m_cnt = 0; m_pend = 0; m_halted = 0; m_last_val = 0; m_last_ovf = 0;
  endfunction

  function automatic void model_char(input logic [7:0] c);
    int v;
    if (c >= 8'h30 && c <= 8'h39) begin
      m_digits.push_back(int'(c) - 48);
      m_cnt = (m_digits.size() < MAXD) ? m_digits.size() : MAXD;
    end else if (c == 8'h0A) begin
      if (m_digits.size() > 0) begin
        v = 0;
        for (int i = 0; i < m_digits.size() && i < MAXD; i++) v = v * 10 + m_digits[i];
        m_last_val = v;
        m_last_ovf = (m_digits.size() > MAXD);
        m_pend = 1;
        m_digits.delete();
      end
    end else if (c != 8'h0D) begin
      m_digits.delete();
      m_cnt = 0;
      m_halted = 1;
    end
  endfunction

  // One clock: drive at negedge, update model at posedge, check at next negedge.
  task automatic step(input logic cv, input logic [7:0] ch, input logic vr, input logic rn);
    char_valid = cv; char_in = ch; val_ready = vr; rst_n = rn;
    @(posedge clk);
    if (!rn) model_reset();
    else if (m_pend) begin
      if (vr) begin m_pend = 0; m_cnt = 0; n_emitted++; end
    end else if (cv && m_ready()) model_char(ch);
    @(negedge clk);
    check_eq("char_ready", 32'(char_ready), 32'(m_ready()));
    check_eq("val_valid",  32'(val_valid),  32'(m_pend));
    check_eq("val_out",    32'(val_out),    32'(m_last_val));
    check_eq("val_ovf",    32'(val_ovf),    32'(m_last_ovf));
    check_eq("halted",     32'(halted),     32'(m_halted));
    if (!m_halted) check_eq("digit_cnt", 32'(digit_cnt), 32'(m_cnt));
  endtask

  function automatic logic pick_vr(input int mode);
    if (mode == 2) return logic'($urandom_range(0, 1));
    return logic'(mode);
  endfunction

  task automatic send_char(input logic [7:0] ch, input int vr_mode);
    int unsigned n;
    bit took;
    n = 0;
    if (m_halted) begin
      step(1'b1, ch, pick_vr(vr_mode), 1'b1);
      return;
    end
    do begin
      took = m_ready();
      step(1'b1, ch, pick_vr(vr_mode), 1'b1);
      n++;
    end while (!took && n < 200);
    if (!took) check_eq("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_str(input string s, input int vr_mode);
    for (int i = 0; i < s.len(); i++) send_char(s[i], vr_mode);
  endtask

  task automatic idle(input int cycles, input logic vr);
    for (int i = 0; i < cycles; i++) step(1'b0, 8'h00, vr, 1'b1);
  endtask

  initial begin
    int emit_before;
    logic [7:0] other_chars [4];
    other_chars[0] = 8'h78; other_chars[1] = 8'h20;
    other_chars[2] = 8'h41; other_chars[3] = 8'hFF;
    rst_n = 1'b0; char_valid = 1'b0; char_in = 8'h00; val_ready = 1'b0;
    @(negedge clk);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    // Single digit, consumer always ready: one-cycle valid pulse.
    send_str("7\n", 1);
    idle(2, 1'b1);

    // Backpressure: value must hold for 5 stalled cycles.
    send_str("1234\n", 0);
    idle(5, 1'b0);
    idle(2, 1'b1);

    // Overflow then a clean short number.
    send_str("98765", 1);
    check_eq("sat_cnt", 32'(digit_cnt), 32'(MAXD));
    send_str("\n", 1);
    send_str("5\n", 1);
    idle(2, 1'b1);

    // Empty lines emit nothing; CR inside a number is ignored.
    emit_before = n_emitted;
    send_str("\n\r\n", 1);
    idle(2, 1'b1);
    check_eq("empty_lines", 32'(n_emitted), 32'(emit_before));
    send_str("42\r\n", 1);
    idle(2, 1'b1);

    // Halt on a stray character; everything after is ignored until reset.
    send_str("12x", 1);
    send_str("a5\n9", 1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    send_str("3\n", 1);
    idle(2, 1'b1);

    // Reset mid-number and mid-output.
    send_str("55", 1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    send_str("66\n", 0);
    idle(1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    send_str("8\n", 1);
    idle(2, 1'b1);

    // Random byte streams with random backpressure and occasional reset.
    for (int it = 0; it < 1500; it++) begin
      int r;
      logic [7:0] c;
      r = int'($urandom_range(0, 99));
      if (m_halted || r < 1) begin
        step(1'b0, 8'h00, 1'b0, 1'b0);
      end else if (r < 12) begin
        idle(1, pick_vr(2));
      end else begin
        r = int'($urandom_range(0, 99));
        if (r < 72)      c = 8'h30 + 8'($urandom_range(0, 9));
        else if (r < 90) c = 8'h0A;
        else if (r < 98) c = 8'h0D;
        else             c = other_chars[$urandom_range(0, 3)];
        send_char(c, 2);
      end
    end
    idle(3, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
